// File: rtl/ext_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ext_sched
//  Purpose  : Round-robin scheduler sharing one immediate extender between
//             decode (requester 0) and branch-target unit (requester 1),
//             with a one-entry valid/ready output register.
//  Options  : EXT_SCHED_STAT_EN adds saturating per-requester grant counters
//             (grant_cnt0 / grant_cnt1).
//  Revision : 1.0 - initial release
// ============================================================================
module ext_sched (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_eop,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_eop,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_ext,
  output logic        resp_id
`ifdef EXT_SCHED_STAT_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  localparam logic [1:0] c_EOP_SEXT    = 2'b00;
  localparam logic [1:0] c_EOP_ZEXT    = 2'b01;
  localparam logic [1:0] c_EOP_HI      = 2'b10;
  localparam logic [1:0] c_EOP_SEXT_S2 = 2'b11;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_resp_ext;
  logic        r_resp_id;
  logic        r_last_grant;

  logic        w_slot_free;
  logic        w_win0;
  logic        w_win1;
  logic        w_load;
  logic        w_load_id;
  logic [31:0] w_ext;

  // The single extender instance on this path.
  function automatic logic [31:0] f_extend(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] res;
    case (eop)
      c_EOP_SEXT:    res = {{16{imm[15]}}, imm};
      c_EOP_ZEXT:    res = {16'h0000, imm};
      c_EOP_HI:      res = {imm, 16'h0000};
      c_EOP_SEXT_S2: res = {{14{imm[15]}}, imm, 2'b00};
      default:       res = {{16{imm[15]}}, imm};
    endcase
    return res;
  endfunction

  assign resp_valid = (r_state == S_FULL);
  assign resp_ext   = r_resp_ext;
  assign resp_id    = r_resp_id;

  // Only the granted requester's operands reach the extender.
  assign w_ext = w_load_id ? f_extend(req1_imm, req1_eop) : f_extend(req0_imm, req0_eop);

  // Arbitration, handshake and next-state: a tie goes to whoever was not granted last.
  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_load      = 1'b0;
    w_load_id   = 1'b0;
    w_slot_free = (r_state == S_EMPTY) || resp_ready;
    w_win0      = req0_valid && (!req1_valid || r_last_grant);
    w_win1      = req1_valid && (!req0_valid || !r_last_grant);

    // Readies are forced low while reset is held.
    if (reset_n && w_slot_free) begin
      req0_ready = w_win0;
      req1_ready = w_win1;
    end

    w_load    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    w_load_id = req1_valid && req1_ready;

    case (r_state)
      S_EMPTY: if (w_load) w_state_nxt = S_FULL;
      S_FULL:  if (resp_ready && !w_load) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // State register; reset drops any held result at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Result register and round-robin pointer, updated only on an acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_ext   <= 32'h0000_0000;
      r_resp_id    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_load) begin
      r_resp_ext   <= w_ext;
      r_resp_id    <= w_load_id;
      r_last_grant <= w_load_id;
    end
  end

`ifdef EXT_SCHED_STAT_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;

  // Saturating acceptance counters, one per requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant_cnt0 <= 16'h0000;
      r_grant_cnt1 <= 16'h0000;
    end else begin
      if (w_load && !w_load_id && (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_load &&  w_load_id && (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ext_sched
//  Purpose  : Self-checking bench for ext_sched: behavioural model checked
//             every cycle, directed literal checks, randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ext_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, resp_ready;
  logic        req0_ready, req1_ready, resp_valid, resp_id;
  logic [15:0] req0_imm, req1_imm;
  logic [1:0]  req0_eop, req1_eop;
  logic [31:0] resp_ext;
`ifdef EXT_SCHED_STAT_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic        m_valid;
  logic [31:0] m_ext;
  logic        m_id;
  logic        m_last;
  logic        m_acc0, m_acc1;
`ifdef EXT_SCHED_STAT_EN
  logic [15:0] m_cnt0, m_cnt1;
`endif

  ext_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_imm   (req0_imm),
    .req0_eop   (req0_eop),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_imm   (req1_imm),
    .req1_eop   (req1_eop),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_ext   (resp_ext),
    .resp_id    (resp_id)
`ifdef EXT_SCHED_STAT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Extension computed with plain integer arithmetic.
  function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] eop);
    int s;
    int u;
    u = int'(imm);
    s = imm[15] ? (u - 65536) : u;
    case (eop)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // Per-cycle compare (called at the falling edge) then advance model past the next rising edge.
  task automatic model_step();
    logic free, e0, e1, win1;
    if (!reset_n) begin
      m_valid = 1'b0; m_ext = 32'h0; m_id = 1'b0; m_last = 1'b1;
`ifdef EXT_SCHED_STAT_EN
      m_cnt0 = 16'h0; m_cnt1 = 16'h0;
`endif
    end
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, m_valid});
    if (m_valid || !reset_n) begin
      chk("resp_ext", resp_ext, m_ext);
      chk("resp_id", {31'b0, resp_id}, {31'b0, m_id});
    end
`ifdef EXT_SCHED_STAT_EN
    chk("grant_cnt0", {16'b0, grant_cnt0}, {16'b0, m_cnt0});
    chk("grant_cnt1", {16'b0, grant_cnt1}, {16'b0, m_cnt1});
`endif
    free = !m_valid || resp_ready;
    win1 = (req0_valid && req1_valid) ? !m_last : req1_valid;
    e0 = reset_n && free && req0_valid && !win1;
    e1 = reset_n && free && req1_valid && win1;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
    m_acc0 = e0;
    m_acc1 = e1;
    if (reset_n) begin
      if (e0 || e1) begin
        m_valid = 1'b1;
        m_id    = e1;
        m_last  = e1;
        m_ext   = e1 ? model_ext(req1_imm, req1_eop) : model_ext(req0_imm, req0_eop);
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
`ifdef EXT_SCHED_STAT_EN
      if (e0 && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
      if (e1 && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
`endif
    end
  endtask

  task automatic cycle(input logic v0, input logic [15:0] i0, input logic [1:0] e0,
                       input logic v1, input logic [15:0] i1, input logic [1:0] e1,
                       input logic rr);
    @(posedge clk); #2;
    req0_valid = v0; req0_imm = i0; req0_eop = e0;
    req1_valid = v1; req1_imm = i1; req1_eop = e1;
    resp_ready = rr;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, rr);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset_n = 1'b0;
    @(negedge clk); model_step();
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk); model_step();
  endtask

  logic [31:0] sweep_exp [4];
  logic [15:0] p_imm0, p_imm1;
  logic [1:0]  p_eop0, p_eop1;

  initial begin
    sweep_exp[0] = 32'hFFFF8000;
    sweep_exp[1] = 32'h00008000;
    sweep_exp[2] = 32'h80000000;
    sweep_exp[3] = 32'hFFFE0000;
    reset_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_imm = 16'h0; req1_imm = 16'h0; req0_eop = 2'd0; req1_eop = 2'd0;

    // Reset values, with requests pending: readies must stay low
    cycle(1'b1, 16'h1111, 2'd0, 1'b1, 16'h2222, 2'd0, 1'b1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_ext", resp_ext, 32'd0);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    @(posedge clk); #2 reset_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); model_step();

    // Tie alternation: 0,1,0,1 without bubbles
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 16'h0010, 2'd0, 1'b1, 16'h0020, 2'd1, 1'b1);
      if (k > 0) begin
        chk("alt_valid", {31'b0, resp_valid}, 32'd1);
        chk("alt_id", {31'b0, resp_id}, 32'(((k - 1) % 2)));
      end
    end
    idle(1'b1);
    chk("alt_id_last", {31'b0, resp_id}, 32'd1);

    // Op sweep on requester 0
    for (int op = 0; op < 4; op++) begin
      cycle(1'b1, 16'h8000, 2'(op), 1'b0, 16'h0, 2'd0, 1'b1);
      if (op > 0) begin
        chk("sweep_ext", resp_ext, sweep_exp[op - 1]);
        chk("sweep_id", {31'b0, resp_id}, 32'd0);
      end
    end
    idle(1'b1);
    chk("sweep_ext3", resp_ext, sweep_exp[3]);

    // Positive immediate on requester 1
    cycle(1'b0, 16'h0, 2'd0, 1'b1, 16'h1234, 2'd0, 1'b1);
    cycle(1'b0, 16'h0, 2'd0, 1'b1, 16'h1234, 2'd3, 1'b1);
    chk("r1_sext", resp_ext, 32'h00001234);
    chk("r1_id", {31'b0, resp_id}, 32'd1);
    idle(1'b1);
    chk("r1_sh2", resp_ext, 32'h000048D0);
    idle(1'b1);

    // Backpressure
    cycle(1'b1, 16'hABCD, 2'd2, 1'b0, 16'h0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 16'h0, 2'd0, 1'b1, 16'h1234, 2'd0, 1'b0);
      chk("bp_hold", resp_ext, 32'hABCD0000);
      chk("bp_ready1", {31'b0, req1_ready}, 32'd0);
    end
    cycle(1'b0, 16'h0, 2'd0, 1'b1, 16'h1234, 2'd0, 1'b1);
    chk("bp_accept1", {31'b0, req1_ready}, 32'd1);
    idle(1'b0);
    chk("bp_result", resp_ext, 32'h00001234);
    chk("bp_id", {31'b0, resp_id}, 32'd1);

    // Asynchronous reset while FULL
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, resp_valid}, 32'd0);
    chk("async_ext", resp_ext, 32'd0);
    @(negedge clk); model_step();
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk); model_step();
    cycle(1'b1, 16'h0001, 2'd0, 1'b1, 16'h0002, 2'd0, 1'b1);
    chk("tie_after_rst0", {31'b0, req0_ready}, 32'd1);
    chk("tie_after_rst1", {31'b0, req1_ready}, 32'd0);
    idle(1'b1);

    // Randomized traffic honouring the hold-while-waiting rule
    p_imm0 = 16'($urandom); p_eop0 = 2'($urandom);
    p_imm1 = 16'($urandom); p_eop1 = 2'($urandom);
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0, p_imm0, p_eop0,
            $urandom_range(0, 3) != 0, p_imm1, p_eop1,
            $urandom_range(0, 3) != 0);
      if (m_acc0 || !req0_valid) begin p_imm0 = 16'($urandom); p_eop0 = 2'($urandom); end
      if (m_acc1 || !req1_valid) begin p_imm1 = 16'($urandom); p_eop1 = 2'($urandom); end
    end
    idle(1'b1);

`ifdef EXT_SCHED_STAT_EN
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 16'h5, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 16'h0, 2'd0, 1'b1, 16'h3, 2'd0, 1'b1);
    idle(1'b1);
    chk("cnt0_five", {16'b0, grant_cnt0}, 32'd5);
    chk("cnt1_three", {16'b0, grant_cnt1}, 32'd3);
    @(posedge clk); #2;
    force dut.r_grant_cnt0 = 16'hFFFF;
    #1 release dut.r_grant_cnt0;
    m_cnt0 = 16'hFFFF;
    @(negedge clk); model_step();
    cycle(1'b1, 16'h7, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    idle(1'b1);
    chk("cnt0_sat", {16'b0, grant_cnt0}, 32'h0000FFFF);
`else
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ext_sched.md
# ext_sched

Two-requester scheduler that shares the single immediate extender between the decode stage (requester 0) and the branch-target unit (requester 1). It arbitrates round-robin, performs the extension selected by each request's `EOp`, and holds the 32-bit result in a one-entry output register under valid/ready handshake. It sits between the requesters and the downstream consumer and contains the only extender instance on this path.

## Interface
- Parameters: none.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous reset, active-low.
- `req0_valid` input 1: requester 0 has a request.
- `req0_ready` output 1: requester 0 accepted this cycle.
- `req0_imm` input 16: requester 0 immediate.
- `req0_eop` input 2: requester 0 extension op.
- `req1_valid` / `req1_ready` / `req1_imm` / `req1_eop`: same for requester 1.
- `resp_valid` output 1: result register holds a result.
- `resp_ready` input 1: consumer takes the result this cycle.
- `resp_ext` output 32: extended value.
- `resp_id` output 1: requester that produced `resp_ext`.
- `grant_cnt0` / `grant_cnt1` output 16 each: accepted-request counters (only with `EXT_SCHED_STAT_EN`).

## Operation
- Extension ops (`EOp`):
  - `00` = sign-extend imm to 32.
  - `01` = zero-extend.
  - `10` = `{imm, 16'h0}`.
  - `11` = sign-extend, then shift left 2.
- Slot free = `!resp_valid || resp_ready`.
- Grant only when slot free.
- Grant rules:
  - One valid requester: it wins.
  - Both valid: the requester not granted last wins.
  - `last_grant` updates only on an actual acceptance.
- `reqN_ready` = slot free AND requester N wins; combinational from valids, `last_grant`, `resp_valid` and `resp_ready`. At most one ready per cycle.
- Acceptance (`reqN_valid && reqN_ready`) loads `resp_ext` = ext(imm, eop), sets `resp_id` = N and sets `resp_valid`.
- States:
  - EMPTY (`resp_valid`=0) -> FULL on acceptance.
  - FULL -> EMPTY on `resp_ready` with no new acceptance.
  - FULL -> FULL on `resp_ready` with an acceptance in the same cycle (drain and refill together).
  - FULL without `resp_ready`: hold `resp_ext`/`resp_id` stable; both readies are 0.
- Requesters must hold imm/eop stable while valid and not ready. A requester that drops valid before ready loses its request; no other state changes.

## Timing
- Reset values:
  - `resp_valid`=0, `resp_ext`=0, `resp_id`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - Grant counters = 0.
- Readies are combinational; 0 whenever `reset_n`=0.
- Latency: accepted in cycle T -> `resp_valid`=1 with the result from cycle T+1.
- Throughput: one result per cycle while `resp_ready` stays high.
- Reset asserted mid-operation: a held result is discarded immediately and asynchronously. No result is produced for a request accepted in the same cycle reset asserts.
- Simultaneous `req0_valid`/`req1_valid` held continuously with `resp_ready`=1: grants alternate 0,1,0,1…

## Configuration
- `EXT_SCHED_STAT_EN` defined:
  - `grant_cnt0`/`grant_cnt1` ports exist.
  - Each increments by 1 on its requester's acceptance and saturates at 16'hFFFF.
  - Both are cleared by reset.
- Not defined: those ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Op sweep on req0 with imm=16'h8000, one op per acceptance, `resp_ready`=1:
  - eop `00` -> resp_ext 32'hFFFF8000.
  - `01` -> 32'h00008000.
  - `10` -> 32'h80000000.
  - `11` -> 32'hFFFE0000.
  - All with resp_id=0, each one cycle after acceptance.
- Positive imm 16'h1234 on req1 with eop `00`/`11` -> 32'h00001234 / 32'h000048D0, resp_id=1.
- Both requesters valid for 4 cycles, `resp_ready`=1 -> grants 0,1,0,1; resp_id sequence 0,1,0,1 with no bubbles.
- Backpressure: accept req0 (eop `10`, imm 16'hABCD), hold `resp_ready`=0 for 3 cycles with req1 valid:
  - resp_ext holds 32'hABCD0000; req1_ready=0 throughout.
  - Raise `resp_ready`: req1 is accepted that same cycle and its result appears the next cycle.
- Assert `reset_n`=0 while FULL -> `resp_valid`=0 and `resp_ext`=0 immediately, without waiting for a clock. After release, the first tie goes to requester 0.
- With `EXT_SCHED_STAT_EN`: 5 req0 and 3 req1 acceptances -> grant_cnt0=5, grant_cnt1=3. A counter preloaded by forcing it to 16'hFFFF stays at 16'hFFFF on the next acceptance.
